// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer: condition codes,
// sequencer states and flag bit positions.
package pc_seq_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Resolves a branch condition code against the registered {N,Z,V} flags.
module branch_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic n;
    logic z;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    // Condition table lookup
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NE:  cond_true = ~z;
            COND_EQ:  cond_true = z;
            COND_GT:  cond_true = ~z & ~n;
            COND_LT:  cond_true = n;
            COND_GE:  cond_true = z | (~z & ~n);
            COND_LE:  cond_true = n | z;
            COND_OV:  cond_true = v;
            COND_UNC: cond_true = 1'b1;
            default:  cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter and N/Z/V flag register. Chooses the next fetch
// address (fall-through, relative/register branch, stall hold, halt) and
// emits a one-cycle flush after every taken redirect.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_reg,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_pc,
    input  logic [15:0] rs_data,
    input  logic [2:0]  flag_we,
    input  logic [2:0]  flags_in,
    input  logic        halt_dec,
    output logic [15:0] pc,
    output logic        taken,
    output logic        flush,
    output logic        halted,
    output logic [2:0]  flags
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [15:0] pc_next;
    logic [15:0] pc_seq;
    logic [15:0] br_offset;
    logic [15:0] rel_target;
    logic [15:0] target;
    logic        cond_true;

    branch_cond_eval u_cond (
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign pc_seq     = pc + 16'd2;
    assign br_offset  = {{6{imm9[8]}}, imm9, 1'b0};
    assign rel_target = br_pc + 16'd2 + br_offset;
    assign target     = br_reg ? rs_data : rel_target;

    // rst_n gates taken so it reads 0 throughout reset, not just after it
    assign taken = rst_n & br_valid & cond_true & (state == RUN);

    // Next-PC selection and run/halt transitions
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (state == RUN) begin
            if (taken) begin
                pc_next = target;
            end else if (stall) begin
                pc_next = pc;
            end else if (halt_dec) begin
                state_next = HALT;
            end else begin
                pc_next = pc_seq;
            end
        end
    end

    // PC, state, flush and halted registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            pc     <= RESET_PC;
            flush  <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            flush  <= taken;
            halted <= (state_next == HALT);
        end
    end

    // Per-bit flag writes, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (flag_we[i]) begin
                    flags[i] <= flags_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        br_reg;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] br_pc;
    logic [15:0] rs_data;
    logic [2:0]  flag_we;
    logic [2:0]  flags_in;
    logic        halt_dec;
    logic [15:0] pc;
    logic        taken;
    logic        flush;
    logic        halted;
    logic [2:0]  flags;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .br_valid (br_valid),
        .br_reg   (br_reg),
        .cond     (cond),
        .imm9     (imm9),
        .br_pc    (br_pc),
        .rs_data  (rs_data),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .halt_dec (halt_dec),
        .pc       (pc),
        .taken    (taken),
        .flush    (flush),
        .halted   (halted),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    logic        m_flush;
    logic        m_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition table written directly from the N/Z/V meaning of each code
    function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
        bit n = f[2];
        bit z = f[1];
        bit v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] m_target();
        int off;
        int t;
        if (br_reg) return rs_data;
        off = (imm9 >= 9'd256) ? int'(imm9) - 512 : int'(imm9);
        t = int'(br_pc) + 2 + off * 2;
        return 16'(t & 32'hFFFF);
    endfunction

    function automatic bit m_taken();
        return !m_halt && br_valid && m_cond(cond, m_flags);
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_flags = 3'b000;
        m_flush = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic clear_inputs();
        stall    = 0;
        br_valid = 0;
        br_reg   = 0;
        cond     = 0;
        imm9     = 0;
        br_pc    = 0;
        rs_data  = 0;
        flag_we  = 0;
        flags_in = 0;
        halt_dec = 0;
    endtask

    // One clock: check taken before the edge, advance model, check registers after
    task automatic step();
        bit t;
        #2;
        t = m_taken();
        check("taken", {31'b0, taken}, {31'b0, t});
        @(posedge clk);
        if (!m_halt) begin
            if (t) m_pc = m_target();
            else if (stall) m_pc = m_pc;
            else if (halt_dec) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
        m_flush = t;
        for (int i = 0; i < 3; i++)
            if (flag_we[i]) m_flags[i] = flags_in[i];
        #1;
        check("pc", {16'b0, pc}, {16'b0, m_pc});
        check("flags", {29'b0, flags}, {29'b0, m_flags});
        check("flush", {31'b0, flush}, {31'b0, m_flush});
        check("halted", {31'b0, halted}, {31'b0, m_halt});
    endtask

    // Mid-cycle asynchronous reset; state must clear before any clock edge
    task automatic async_reset();
        br_valid = 1;
        cond     = 3'b111;
        rst_n    = 0;
        #1;
        check("rst_pc", {16'b0, pc}, {16'b0, RST_PC});
        check("rst_flags", {29'b0, flags}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_taken", {31'b0, taken}, 32'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        #12;
        async_reset();

        // Sequencing from reset
        for (int i = 0; i < 3; i++) step();
        check("seq_pc", {16'b0, pc}, 32'h0106);

        // Z=1, then EQ relative branch backwards
        flag_we = 3'b010; flags_in = 3'b010; step();
        clear_inputs();
        br_valid = 1; cond = 3'b001; br_pc = 16'h0200; imm9 = 9'h1FE;
        step();
        check("b_rel_pc", {16'b0, pc}, 32'h01FE);
        check("b_rel_flush", {31'b0, flush}, 32'd1);
        clear_inputs();
        step();
        check("flush_one", {31'b0, flush}, 32'd0);

        // Wrap on relative target
        br_valid = 1; cond = 3'b111; br_pc = 16'hFFFE; imm9 = 9'h000;
        step();
        check("b_wrap", {16'b0, pc}, 32'h0000);
        clear_inputs();

        // Condition sweep: every code against every flag combination
        for (int f = 0; f < 8; f++) begin
            clear_inputs();
            flag_we = 3'b111; flags_in = 3'(f);
            step();
            for (int c = 0; c < 8; c++) begin
                clear_inputs();
                br_valid = 1; cond = 3'(c); br_pc = 16'($urandom); imm9 = 9'($urandom);
                step();
            end
        end

        // Same-cycle flag write is not seen by the branch
        clear_inputs();
        flag_we = 3'b111; flags_in = 3'b000; step();
        br_valid = 1; cond = 3'b001; flag_we = 3'b010; flags_in = 3'b010;
        step();
        check("old_flag_taken", {31'b0, flush}, 32'd0);
        clear_inputs();
        br_valid = 1; cond = 3'b001; br_pc = 16'h0300;
        step();
        check("new_flag_taken", {31'b0, flush}, 32'd1);

        // Register branch overrides stall, LSB kept
        clear_inputs();
        stall = 1; br_valid = 1; br_reg = 1; cond = 3'b111; rs_data = 16'h1235;
        step();
        check("br_reg_pc", {16'b0, pc}, 32'h1235);
        clear_inputs();
        stall = 1;
        for (int i = 0; i < 4; i++) step();
        check("stall_hold", {16'b0, pc}, 32'h1235);

        // Halt at 0x0040
        clear_inputs();
        br_valid = 1; br_reg = 1; cond = 3'b111; rs_data = 16'h0040;
        step();
        clear_inputs();
        halt_dec = 1;
        step();
        check("halt_hi", {31'b0, halted}, 32'd1);
        check("halt_pc", {16'b0, pc}, 32'h0040);
        clear_inputs();
        br_valid = 1; cond = 3'b111; br_pc = 16'h0500;
        step();
        check("halt_ignore", {16'b0, pc}, 32'h0040);
        clear_inputs();
        flag_we = 3'b111; flags_in = 3'b111;
        step();
        check("halt_flags", {29'b0, flags}, 32'd7);
        clear_inputs();
        #3;
        async_reset();

        // Halt squashed by simultaneous taken branch
        clear_inputs();
        halt_dec = 1; br_valid = 1; cond = 3'b111; br_pc = 16'h0800; imm9 = 9'h004;
        step();
        check("squash_halt", {31'b0, halted}, 32'd0);
        check("squash_pc", {16'b0, pc}, 32'h080A);
        clear_inputs();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            br_valid = ($urandom_range(0, 2) == 0);
            br_reg   = 1'($urandom);
            cond     = 3'($urandom);
            imm9     = 9'($urandom);
            br_pc    = 16'($urandom);
            rs_data  = 16'($urandom);
            flag_we  = 3'($urandom);
            flags_in = 3'($urandom);
            halt_dec = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) async_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the fetch program counter and the N/Z/V flag register for the pipelined 16-bit core. Each cycle it selects the next fetch address: fall-through, relative branch, register branch, stall hold or halt. It resolves branch conditions against the registered flags and emits a one-cycle flush when a redirect is taken. It sits between the decode-stage branch logic and the instruction-memory address port.

## Interface
- RESET_PC, 16'h0000, fetch address loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard hold; PC and state unchanged unless a redirect is taken
- br_valid  in  1  decode stage holds a branch this cycle
- br_reg  in  1  1 = register branch (BR), 0 = relative branch (B)
- cond  in  3  branch condition code
- imm9  in  9  signed word offset for B
- br_pc  in  16  address of the branch instruction
- rs_data  in  16  target for BR
- flag_we  in  3  per-flag write enables {N,Z,V}
- flags_in  in  3  new flag values {N,Z,V}
- halt_dec  in  1  HLT decoded this cycle
- pc  out  16  current fetch address
- taken  out  1  combinational; branch resolved taken this cycle
- flush  out  1  registered; high exactly one cycle after a taken branch
- halted  out  1  registered; high in HALT
- flags  out  3  registered {N,Z,V}

## Operation
- FSM states: RUN, HALT. Reset enters RUN; HALT exits only via rst_n.
- Condition codes: 000 NE (Z=0), 001 EQ (Z=1), 010 GT (Z=0 & N=0), 011 LT (N=1), 100 GE (Z=1 | (Z=0 & N=0)), 101 LE (N=1 | Z=1), 110 OV (V=1), 111 unconditional.
- taken = br_valid & cond_true & state==RUN. Conditions are evaluated against the registered flags, never flags_in.
- B target = br_pc + 2 + (sext16(imm9) << 1), modulo 2^16; no overflow reporting. BR target = rs_data exactly; the LSB is not masked.
- Next-PC priority in RUN: taken → target; else stall → hold; else halt_dec → hold and go to HALT; else pc + 2 (wraps FFFE→0000).
- A taken branch overrides a simultaneous stall and halt_dec, because the younger halt is squashed.
- In HALT: pc holds, taken=0, flush=0, and br_valid and halt_dec are ignored.
- Flags: each bit loads flags_in when its flag_we bit is set, including during stall and HALT.

## Timing
- Reset values: pc=RESET_PC, flags=3'b000, flush=0, halted=0, state=RUN. taken is 0 while rst_n is low.
- Redirect latency: pc shows the target on the edge after taken; flush is high in that same following cycle.
- Flag update latency: one cycle. A branch in the same cycle as a flag write sees the old value.
- halted rises on the edge that latches halt_dec. pc then holds the address it had when halt_dec was sampled.
- Asserting rst_n mid-operation, including in HALT or during flush, returns all state to its reset values immediately.

## Structure
- Package pc_seq_pkg holds:
  - condition-code localparams (COND_NE … COND_UNC);
  - the state enum {RUN, HALT};
  - flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0.
- Sub-module branch_cond_eval: takes cond and flags, returns cond_true; purely combinational.
- Target adders are inline and separate: one for pc + 2, one for br_pc + 2 + offset.

## Test plan
- Reset and sequencing: RESET_PC=16'h0100, no stimulus → pc steps 0100, 0102, 0104; flush, halted and taken stay 0.
- Relative branch and wrap: flags Z=1, br_valid, cond=001, br_pc=16'h0200, imm9=9'h1FE (−2) → taken=1; next pc=16'h01FE; flush high exactly one cycle. With br_pc=16'hFFFE, imm9=0 → pc=16'h0000.
- Condition sweep: all 8 codes × 8 flag combinations → taken matches the table. Writing Z=1 with flag_we in the branch cycle has no effect on that branch; the write is visible next cycle.
- Register branch vs stall: stall=1 with br_reg=1, cond=111, rs_data=16'h1235 → pc=16'h1235 next cycle (LSB kept). Stall alone → pc held for N cycles.
- Halt: halt_dec at pc=16'h0040 → halted=1 next cycle, pc stays 0040. Later br_valid with cond=111 → ignored. halt_dec together with a taken branch → redirect, no halt.
- Async reset: drop rst_n mid-cycle while in HALT with flags=3'b111 → pc=RESET_PC, flags=0, halted=0 without waiting for a clock edge.
